// File: rtl/vector_load_wb.sv
// vector_load_wb: load sequencer that fetches one (scalar) or four (vector) 32-bit words
// from memory and writes them to the register file as a single 128-bit write-back.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   start, dest         load request and destination register (dest[4:3]==2'b11 -> vector)
//   base_addr           byte address of beat 0
//   busy, done          busy in every state but idle; done pulses for one cycle at the end
//   mem_req, mem_addr   read request (held until acknowledged) and address of current beat
//   mem_ack, mem_rdata  read data valid and read data
//   we3, a3, wd3        register-file write port
//
// Optional feature (macro VLOAD_ERR_EN): adds input mem_err (qualified by mem_ack) and output
// err. An errored beat aborts the load through a one-cycle error state with no register write.
module vector_load_wb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STRIDE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        dest,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
`ifdef VLOAD_ERR_EN
  input  logic              mem_err,
  output logic              err,
`endif
  output logic              we3,
  output logic [4:0]        a3,
  output logic [127:0]      wd3
);

`ifdef VLOAD_ERR_EN
  typedef enum logic [1:0] {StIdle, StReq, StWb, StErr} state_e;
`else
  typedef enum logic [1:0] {StIdle, StReq, StWb} state_e;
`endif

  state_e                 state_q, state_d;
  logic [4:0]             dest_q, dest_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [1:0]             beat_q, beat_d;
  logic [3:0][31:0]       lane_q, lane_d;

  logic                   is_vec;
  logic                   last_beat;
  logic                   accept;
  logic [ADDR_W-1:0]      offset;

  assign is_vec    = (dest_q[4:3] == 2'b11);
  assign last_beat = is_vec ? (beat_q == 2'd3) : 1'b1;

  // Address arithmetic is deliberately modulo 2^ADDR_W so a load may wrap past the top.
  assign offset    = ADDR_W'(STRIDE) * ADDR_W'(beat_q);
  assign mem_addr  = base_q + offset;
  assign a3        = dest_q;
  assign wd3       = lane_q;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    base_d  = base_q;
    beat_d  = beat_q;
    lane_d  = lane_q;
    busy    = 1'b1;
    done    = 1'b0;
    mem_req = 1'b0;
    we3     = 1'b0;
    accept  = 1'b0;
`ifdef VLOAD_ERR_EN
    err     = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          dest_d  = dest;
          base_d  = base_addr;
          beat_d  = 2'd0;
          // Clear lanes so a scalar load (or an aborted one) never exposes old data.
          lane_d  = '0;
          state_d = StReq;
        end
      end

      StReq: begin
        mem_req = 1'b1;
        if (mem_ack) begin
`ifdef VLOAD_ERR_EN
          if (mem_err) begin
            state_d = StErr;
          end else begin
            accept = 1'b1;
          end
`else
          accept = 1'b1;
`endif
        end
        if (accept) begin
          lane_d[beat_q] = mem_rdata;
          beat_d         = beat_q + 2'd1;
          if (last_beat) begin
            state_d = StWb;
          end
        end
      end

      StWb: begin
        done    = 1'b1;
        // Register 0 is never written, but the load still completes.
        we3     = (dest_q != 5'd0);
        state_d = StIdle;
      end

`ifdef VLOAD_ERR_EN
      StErr: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = StIdle;
      end
`endif

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dest_q  <= '0;
      base_q  <= '0;
      beat_q  <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      lane_q  <= lane_d;
    end
  end

endmodule

// File: tb/tb_vector_load_wb.sv
module tb_vector_load_wb;

  typedef struct {
    logic         we;
    logic [4:0]   a;
    logic [127:0] wd;
  } wb_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [4:0]   dest;
  logic [31:0]  base_addr;
  logic         busy;
  logic         done;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         we3;
  logic [4:0]   a3;
  logic [127:0] wd3;
  logic         mem_err;
  logic         err;

  int n_pass;
  int n_total;

  logic [31:0] rd_tab [4];
  logic [31:0] addr_q [$];
  wb_t         wb_q [$];

  vector_load_wb #(
    .ADDR_W(32),
    .STRIDE(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dest      (dest),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
`ifdef VLOAD_ERR_EN
    .mem_err   (mem_err),
    .err       (err),
`endif
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3)
  );

`ifndef VLOAD_ERR_EN
  assign err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one load; inputs change on the falling edge, outputs are sampled 3 time units later.
  // Expected addresses and write-back are queued up front and consumed as the DUT produces them.
  task automatic do_load(input logic [4:0] d, input logic [31:0] base, input int stall_beat,
                         input int stall_n, input bit hold_start, output int lat);
    wb_t e;
    wb_t got;
    int  nb;
    int  cyc;
    int  beat;
    int  stalled;
    bit  seen;
    nb = (d[4:3] == 2'b11) ? 4 : 1;
    for (int k = 0; k < nb; k++) addr_q.push_back(base + 32'(4 * k));
    e.we = (d != 5'd0);
    e.a  = d;
    e.wd = (nb == 4) ? {rd_tab[3], rd_tab[2], rd_tab[1], rd_tab[0]} : {96'b0, rd_tab[0]};
    wb_q.push_back(e);

    @(negedge clk);
    start = 1'b1; dest = d; base_addr = base; mem_ack = 1'b1; mem_err = 1'b0;
    @(negedge clk);
    if (hold_start) begin
      dest = 5'h1f; base_addr = 32'h0;
    end else begin
      start = 1'b0;
    end
    cyc = 1; beat = 0; stalled = 0; seen = 0; lat = -1;
    while (cyc < 40 && !seen) begin
      mem_ack   = !(beat == stall_beat && stalled < stall_n);
      mem_rdata = rd_tab[beat % 4];
      #3;
      if (mem_req) begin
        n_total++;
        if (addr_q.size() == 0)
          $display("FAIL beat_addr d=%0d: unexpected beat at %h, want none", d, mem_addr);
        else if (mem_addr !== addr_q[0])
          $display("FAIL beat_addr d=%0d beat=%0d: got %h want %h", d, beat, mem_addr, addr_q[0]);
        else n_pass++;
        if (mem_ack) begin
          if (addr_q.size() != 0) void'(addr_q.pop_front());
          beat++;
        end else begin
          stalled++;
        end
      end
      if (done) begin
        seen = 1;
        lat  = cyc;
        got  = wb_q.pop_front();
        n_total++;
        if (we3 !== got.we) $display("FAIL wb_we3 d=%0d: got %b want %b", d, we3, got.we);
        else n_pass++;
        n_total++;
        if (a3 !== got.a) $display("FAIL wb_a3 d=%0d: got %h want %h", d, a3, got.a);
        else n_pass++;
        n_total++;
        if (wd3 !== got.wd) $display("FAIL wb_wd3 d=%0d: got %h want %h", d, wd3, got.wd);
        else n_pass++;
      end else begin
        n_total++;
        if (we3 !== 1'b0) $display("FAIL we3_outside_wb d=%0d: got %b want 0", d, we3);
        else n_pass++;
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      n_total++;
      $display("FAIL load_timeout d=%0d: no done within 40 cycles, want done", d);
      wb_q.delete();
    end
    n_total++;
    if (addr_q.size() != 0) begin
      $display("FAIL beats_missing d=%0d: got %0d left want 0", d, addr_q.size());
      addr_q.delete();
    end else n_pass++;
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b1;
    #3;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL idle_after d=%0d: got busy=%b done=%b want 0 0", d, busy, done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; dest = 5'h1a; base_addr = 32'h1234; mem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #3;
    n_total++;
    if ({busy, done, mem_req, we3} !== 4'b0)
      $display("FAIL reset_ctrl: got %b want 0000", {busy, done, mem_req, we3});
    else n_pass++;
    n_total++;
    if (a3 !== 5'd0) $display("FAIL reset_a3: got %h want 0", a3); else n_pass++;
    n_total++;
    if (wd3 !== 128'd0) $display("FAIL reset_wd3: got %h want 0", wd3); else n_pass++;
    n_total++;
    if (mem_addr !== 32'd0) $display("FAIL reset_addr: got %h want 0", mem_addr); else n_pass++;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_vector();
    int lat;
    rd_tab[0] = 32'hA0; rd_tab[1] = 32'hA1; rd_tab[2] = 32'hA2; rd_tab[3] = 32'hA3;
    do_load(5'b11010, 32'h100, -1, 0, 1'b0, lat);
    n_total++;
    if (lat !== 5) $display("FAIL vector_latency: got %0d want 5", lat); else n_pass++;
  endtask

  task automatic test_scalar();
    int lat;
    rd_tab[0] = 32'hDEADBEEF; rd_tab[1] = 32'h11111111;
    rd_tab[2] = 32'h22222222; rd_tab[3] = 32'h33333333;
    do_load(5'd7, 32'h40, -1, 0, 1'b0, lat);
    n_total++;
    if (lat !== 2) $display("FAIL scalar_latency: got %0d want 2", lat); else n_pass++;
  endtask

  task automatic test_stall();
    int lat;
    rd_tab[0] = 32'h0BAD0000; rd_tab[1] = 32'h0BAD0001;
    rd_tab[2] = 32'h0BAD0002; rd_tab[3] = 32'h0BAD0003;
    do_load(5'b11101, 32'h2000, 2, 3, 1'b0, lat);
    n_total++;
    if (lat !== 8) $display("FAIL stall_latency: got %0d want 8", lat); else n_pass++;
  endtask

  task automatic test_wrap();
    int lat;
    rd_tab[0] = 32'hC0; rd_tab[1] = 32'hC1; rd_tab[2] = 32'hC2; rd_tab[3] = 32'hC3;
    do_load(5'b11000, 32'hFFFFFFF8, -1, 0, 1'b0, lat);
  endtask

  // start is held high through the whole load (including the write-back cycle) with a
  // different dest; the write-back must still match the first request.
  task automatic test_back_to_back();
    int lat;
    rd_tab[0] = 32'h5A5A0000; rd_tab[1] = 32'h5A5A0001;
    rd_tab[2] = 32'h5A5A0002; rd_tab[3] = 32'h5A5A0003;
    do_load(5'b11011, 32'h8000, -1, 0, 1'b1, lat);
    n_total++;
    if (lat !== 5) $display("FAIL busy_start_latency: got %0d want 5", lat); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    int lat;
    int we_seen;
    rd_tab[0] = 32'hE0; rd_tab[1] = 32'hE1; rd_tab[2] = 32'hE2; rd_tab[3] = 32'hE3;
    @(negedge clk);
    start = 1'b1; dest = 5'b11001; base_addr = 32'h200; mem_ack = 1'b1;
    mem_rdata = rd_tab[0];
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1; mem_rdata = rd_tab[1];
    @(negedge clk);
    rst = 1'b0;
    #3;
    n_total++;
    if ({busy, mem_req, we3, done} !== 4'b0)
      $display("FAIL rst_mid_ctrl: got %b want 0000", {busy, mem_req, we3, done});
    else n_pass++;
    n_total++;
    if (wd3 !== 128'd0) $display("FAIL rst_mid_wd3: got %h want 0", wd3); else n_pass++;
    we_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #3;
      if (we3 === 1'b1) we_seen++;
    end
    n_total++;
    if (we_seen != 0) $display("FAIL rst_mid_no_write: got %0d writes want 0", we_seen);
    else n_pass++;
    do_load(5'd0, 32'h300, -1, 0, 1'b0, lat);
    n_total++;
    if (lat !== 2) $display("FAIL dest0_latency: got %0d want 2", lat); else n_pass++;
  endtask

`ifdef VLOAD_ERR_EN
  task automatic test_error();
    @(negedge clk);
    start = 1'b1; dest = 5'b11000; base_addr = 32'h500; mem_ack = 1'b1; mem_err = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    mem_err = 1'b1;
    @(negedge clk);
    mem_err = 1'b0;
    #3;
    n_total++;
    if ({err, done, we3, busy} !== 4'b1101)
      $display("FAIL err_state: got %b want 1101", {err, done, we3, busy});
    else n_pass++;
    @(negedge clk);
    #3;
    n_total++;
    if ({err, done, busy} !== 3'b000)
      $display("FAIL err_exit: got %b want 000", {err, done, busy});
    else n_pass++;
  endtask
`endif

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; start = 1'b0; dest = 5'd0; base_addr = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0; mem_err = 1'b0;
    for (int i = 0; i < 4; i++) rd_tab[i] = 32'd0;
    test_reset();
    test_vector();
    test_scalar();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid_load();
`ifdef VLOAD_ERR_EN
    test_error();
`endif
    n_total++;
    if (err !== 1'b0) $display("FAIL err_idle: got %b want 0", err); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
